// File: rtl/pkt_rx_parser.sv
// Byte-stream packet receiver: strips the 6-byte header into shadow registers,
// packs payload bytes into 16-bit words and publishes the header on completion.
module pkt_rx_parser #(
  parameter int unsigned MAX_LEN = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_byte,
  input  logic        in_valid,
  input  logic        in_sop,
  output logic        in_ready,
  output logic [2:0]  fPktType,
  output logic [15:0] sourceID,
  output logic [15:0] destinationID,
  output logic [7:0]  payloadLen,
  output logic        newpkt,
  output logic [15:0] pay_word,
  output logic        pay_valid,
  output logic        err
);
  localparam logic [7:0] MaxLen  = 8'(MAX_LEN);
  localparam logic [7:0] Timeout = 8'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, HDR, PAYLOAD, DONE} state_e;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d, idle_q, idle_d, hold_q, hold_d;
  logic [2:0]  typ_sh_q, typ_sh_d;
  logic [15:0] src_sh_q, src_sh_d, dst_sh_q, dst_sh_d;
  logic [7:0]  len_sh_q, len_sh_d;
  logic [15:0] word_q, word_d;
  logic        pv_q, pv_d, err_q, err_d;
  logic        rdy_q, newpkt_q;
  logic [2:0]  type_q;
  logic [15:0] src_q, dst_q;
  logic [7:0]  len_q;
  logic        xfer, start, abort;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idle_d   = idle_q;
    hold_d   = hold_q;
    typ_sh_d = typ_sh_q;
    src_sh_d = src_sh_q;
    dst_sh_d = dst_sh_q;
    len_sh_d = len_sh_q;
    word_d   = word_q;
    pv_d     = 1'b0;
    start    = 1'b0;
    abort    = 1'b0;
    xfer     = in_valid && rdy_q;
    case (state_q)
      IDLE: if (xfer && in_sop) start = 1'b1;
      HDR, PAYLOAD: begin
        if (xfer && in_sop) begin
          abort = 1'b1;
          start = 1'b1;
        end else if (xfer) begin
          idle_d = 8'd0;
          if (state_q == HDR) begin
            cnt_d = cnt_q + 8'd1;
            case (cnt_q)
              8'd0: src_sh_d[15:8] = in_byte;
              8'd1: src_sh_d[7:0]  = in_byte;
              8'd2: dst_sh_d[15:8] = in_byte;
              8'd3: dst_sh_d[7:0]  = in_byte;
              default: begin
                len_sh_d = in_byte;
                cnt_d    = 8'd0;
                if (in_byte == 8'd0)         state_d = DONE;
                else if (in_byte <= MaxLen)  state_d = PAYLOAD;
                else                         abort   = 1'b1;
              end
            endcase
          end else begin
            cnt_d = cnt_q + 8'd1;
            if (!cnt_q[0]) hold_d = in_byte;
            else begin
              pv_d   = 1'b1;
              word_d = {hold_q, in_byte};
            end
            // Odd tail byte goes out alone, left-justified.
            if (cnt_q + 8'd1 == len_sh_q) begin
              state_d = DONE;
              cnt_d   = 8'd0;
              if (!cnt_q[0]) begin
                pv_d   = 1'b1;
                word_d = {in_byte, 8'h00};
              end
            end
          end
        end else begin
          idle_d = idle_q + 8'd1;
          if (idle_q + 8'd1 == Timeout) abort = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d = IDLE;
      cnt_d   = 8'd0;
      idle_d  = 8'd0;
      hold_d  = 8'd0;
    end
    // A sop byte always restarts framing, even when it also aborted the old packet.
    if (start) begin
      cnt_d  = 8'd0;
      idle_d = 8'd0;
      hold_d = 8'd0;
      if (in_byte[7:5] == 3'b111) begin
        abort   = 1'b1;
        state_d = IDLE;
      end else begin
        typ_sh_d = in_byte[7:5];
        state_d  = HDR;
      end
    end
    err_d = abort;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= 8'd0;
      idle_q   <= 8'd0;
      hold_q   <= 8'd0;
      typ_sh_q <= 3'd0;
      src_sh_q <= 16'd0;
      dst_sh_q <= 16'd0;
      len_sh_q <= 8'd0;
      word_q   <= 16'd0;
      pv_q     <= 1'b0;
      err_q    <= 1'b0;
      rdy_q    <= 1'b0;
      newpkt_q <= 1'b0;
      type_q   <= 3'd0;
      src_q    <= 16'd0;
      dst_q    <= 16'd0;
      len_q    <= 8'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idle_q   <= idle_d;
      hold_q   <= hold_d;
      typ_sh_q <= typ_sh_d;
      src_sh_q <= src_sh_d;
      dst_sh_q <= dst_sh_d;
      len_sh_q <= len_sh_d;
      word_q   <= word_d;
      pv_q     <= pv_d;
      err_q    <= err_d;
      rdy_q    <= (state_d != DONE);
      newpkt_q <= (state_d == DONE);
      if (state_d == DONE && state_q != DONE) begin
        type_q <= typ_sh_d;
        src_q  <= src_sh_d;
        dst_q  <= dst_sh_d;
        len_q  <= len_sh_d;
      end
    end
  end

  assign in_ready      = rdy_q;
  assign fPktType      = type_q;
  assign sourceID      = src_q;
  assign destinationID = dst_q;
  assign payloadLen    = len_q;
  assign newpkt        = newpkt_q;
  assign pay_word      = word_q;
  assign pay_valid     = pv_q;
  assign err           = err_q;
endmodule

// File: tb/tb_pkt_rx_parser.sv
// Scoreboard bench for pkt_rx_parser: expected words, packets and error pulses
// are queued as bytes are driven and retired by a negedge monitor.
module tb_pkt_rx_parser;
  localparam int MAX_LEN = 32;
  localparam int TIMEOUT = 255;

  logic        clk = 1'b0, rst = 1'b1;
  logic [7:0]  in_byte = 8'd0;
  logic        in_valid = 1'b0, in_sop = 1'b0;
  logic        in_ready, newpkt, pay_valid, err;
  logic [2:0]  fPktType;
  logic [15:0] sourceID, destinationID, pay_word;
  logic [7:0]  payloadLen;

  pkt_rx_parser #(.MAX_LEN(MAX_LEN), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .in_byte(in_byte), .in_valid(in_valid), .in_sop(in_sop),
    .in_ready(in_ready), .fPktType(fPktType), .sourceID(sourceID),
    .destinationID(destinationID), .payloadLen(payloadLen), .newpkt(newpkt),
    .pay_word(pay_word), .pay_valid(pay_valid), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_err = 0;
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%0h exp=%0h (cyc %0d)", tag, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [2:0]  t;
    logic [15:0] s;
    logic [15:0] d;
    logic [7:0]  l;
    int          c;
  } pkt_t;

  pkt_t        pkt_q[$];
  logic [15:0] pw_q[$];
  int          err_lo[$], err_hi[$];
  pkt_t        last;
  int          last_c;

  // Monitor: every DUT event must match the head of its queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (pay_valid) begin
        if (pw_q.size() == 0) chk("pay_unexp", 1, 0);
        else chk("pay_word", pay_word, pw_q.pop_front());
      end
      if (newpkt) begin
        if (pkt_q.size() == 0) chk("newpkt_unexp", 1, 0);
        else begin
          pkt_t p;
          p = pkt_q.pop_front();
          chk("type", fPktType, p.t);
          chk("src", sourceID, p.s);
          chk("dst", destinationID, p.d);
          chk("len", payloadLen, p.l);
          chk("newpkt_cyc", cyc, p.c);
          chk("rdy_in_done", in_ready, 0);
        end
      end
      if (err) begin
        if (err_lo.size() == 0) chk("err_unexp", 1, 0);
        else begin
          int lo, hi;
          lo = err_lo.pop_front();
          hi = err_hi.pop_front();
          chk("err_cyc", (cyc >= lo && cyc <= hi) ? 32'd1 : 32'd0, 1);
        end
      end
    end
  end

  task automatic put(input logic [7:0] b, input logic s);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      in_valid = 1'b0;
      in_sop   = 1'b0;
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("rdy_wait", 0, 1);
    in_byte  = b;
    in_sop   = s;
    in_valid = 1'b1;
    last_c   = cyc;
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_sop   = 1'b0;
    end
  endtask

  task automatic exp_err(input int lo, input int hi);
    err_lo.push_back(lo);
    err_hi.push_back(hi);
  endtask

  task automatic send_hdr(input logic [2:0] t, input logic [15:0] s, input logic [15:0] d,
                          input logic [7:0] l, input int gap, input bit abort_first);
    put({t, 5'h15}, 1'b1);
    if (abort_first) exp_err(last_c + 1, last_c + 1);
    if (gap > 0) idle(gap);
    put(s[15:8], 1'b0); if (gap > 0) idle(gap);
    put(s[7:0], 1'b0);  if (gap > 0) idle(gap);
    put(d[15:8], 1'b0); if (gap > 0) idle(gap);
    put(d[7:0], 1'b0);  if (gap > 0) idle(gap);
    put(l, 1'b0);
  endtask

  task automatic send_pkt(input logic [2:0] t, input logic [15:0] s, input logic [15:0] d,
                          input logic [7:0] l, input int gap, input bit abort_first);
    logic [7:0] b, hi;
    pkt_t p;
    hi = 8'd0;
    send_hdr(t, s, d, l, gap, abort_first);
    for (int i = 0; i < int'(l); i++) begin
      if (gap > 0) idle(gap);
      b = 8'($urandom);
      if (i % 2 == 0) begin
        hi = b;
        if (i == int'(l) - 1) pw_q.push_back({b, 8'h00});
      end else pw_q.push_back({hi, b});
      put(b, 1'b0);
    end
    p = '{t, s, d, l, last_c + 1};
    pkt_q.push_back(p);
    last = p;
  endtask

  task automatic chk_held(input string tag);
    chk({tag, "_type"}, fPktType, last.t);
    chk({tag, "_src"}, sourceID, last.s);
    chk({tag, "_dst"}, destinationID, last.d);
    chk({tag, "_len"}, payloadLen, last.l);
  endtask

  initial begin
    pkt_t p;
    repeat (3) @(negedge clk);
    chk("rst_rdy", in_ready, 0);
    chk("rst_type", fPktType, 0);
    chk("rst_src", sourceID, 0);
    chk("rst_dst", destinationID, 0);
    chk("rst_len", payloadLen, 0);
    chk("rst_outs", {newpkt, pay_valid, err}, 0);
    chk("rst_word", pay_word, 0);
    rst = 1'b0;
    #1 chk("rdy_pre_edge", in_ready, 0);
    @(negedge clk);
    chk("rdy_after_rst", in_ready, 1);

    // Reference packet with literal bytes.
    pw_q.push_back(16'h1122);
    pw_q.push_back(16'h3300);
    put(8'hA0, 1'b1); put(8'h00, 1'b0); put(8'h05, 1'b0); put(8'h00, 1'b0);
    put(8'h09, 1'b0); put(8'h03, 1'b0); put(8'h11, 1'b0); put(8'h22, 1'b0);
    put(8'h33, 1'b0);
    p = '{3'd5, 16'h0005, 16'h0009, 8'd3, last_c + 1};
    pkt_q.push_back(p);
    last = p;

    // Header-only packet; in_ready must be back the cycle after DONE.
    put(8'h20, 1'b1); put(8'h00, 1'b0); put(8'h01, 1'b0); put(8'h00, 1'b0);
    put(8'h02, 1'b0); put(8'h00, 1'b0);
    p = '{3'd1, 16'h0001, 16'h0002, 8'd0, last_c + 1};
    pkt_q.push_back(p);
    last = p;
    @(negedge clk);
    @(negedge clk);
    chk("rdy_one_low", in_ready, 1);

    // Back-to-back variety, including the MAX_LEN boundary and gapped bytes.
    send_pkt(3'd2, 16'hBEEF, 16'hCAFE, 8'd4, 0, 1'b0);
    send_pkt(3'd6, 16'h1234, 16'h5678, 8'd1, 0, 1'b0);
    send_pkt(3'd0, 16'hFFFF, 16'h0000, 8'(MAX_LEN), 0, 1'b0);
    send_pkt(3'd3, 16'hA5A5, 16'h5A5A, 8'd5, 3, 1'b0);
    idle(2);

    // Reserved type aborts at byte0 and leaves published header alone.
    put(8'hE0, 1'b1);
    exp_err(last_c + 1, last_c + 1);
    idle(3);
    chk_held("type7_hold");

    // Oversized lengths.
    send_hdr(3'd4, 16'h0101, 16'h0202, 8'h40, 0, 1'b0);
    exp_err(last_c + 1, last_c + 1);
    idle(2);
    send_hdr(3'd4, 16'h0303, 16'h0404, 8'(MAX_LEN + 1), 0, 1'b0);
    exp_err(last_c + 1, last_c + 1);
    idle(3);
    chk_held("oversize_hold");

    // Stall after byte3 until the idle timeout fires.
    put(8'hA0, 1'b1); put(8'h00, 1'b0); put(8'h05, 1'b0); put(8'h00, 1'b0);
    exp_err(last_c + 1 + TIMEOUT - 5, last_c + 1 + TIMEOUT + 5);
    idle(TIMEOUT + 15);
    chk_held("timeout_hold");
    send_pkt(3'd5, 16'h0777, 16'h0888, 8'd2, 0, 1'b0);

    // sop mid-payload after a full pair plus a dangling half word.
    send_hdr(3'd1, 16'h1111, 16'h2222, 8'd6, 0, 1'b0);
    pw_q.push_back(16'hC0DE);
    put(8'hC0, 1'b0); put(8'hDE, 1'b0); put(8'h99, 1'b0);
    send_pkt(3'd2, 16'h3333, 16'h4444, 8'd3, 0, 1'b1);

    // Reset in the middle of a header, then stray non-sop bytes.
    put(8'h60, 1'b1); put(8'h12, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    #2;
    chk("mid_rst_rdy", in_ready, 0);
    chk("mid_rst_outs", {newpkt, pay_valid, err}, 0);
    chk("mid_rst_type", fPktType, 0);
    @(negedge clk);
    rst = 1'b0;
    put(8'h11, 1'b0); put(8'h22, 1'b0); put(8'h33, 1'b0);
    idle(3);
    send_pkt(3'd6, 16'h0A0B, 16'h0C0D, 8'd2, 0, 1'b0);

    idle(10);
    chk("pkt_q_left", pkt_q.size(), 0);
    chk("pw_q_left", pw_q.size(), 0);
    chk("err_q_left", err_lo.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired (cyc %0d)", cyc);
    $fatal(1, "watchdog");
  end
endmodule
